dbg_scan_ctrl: RTL
==================

Name: dbg_scan_ctrl

Overview:
Parametrised debug-view scanner for the SCPU board top. It replaces the fixed per-source scan registers (instruction, register file, ALU, data memory) with one engine.
- Selects one of NCH probe channels by one-hot switch input.
- Walks an index through that channel at a programmable rate, or one step per button press.
- Optionally inserts an end-of-sweep marker word after the last index.
- Presents a 32-bit word, with its channel and index tags, to the seven-segment driver.

Parameters:
DATA_W, 32, display/probe word width
NCH, 4, number of probe channels
IDX_W, 6, index width per channel
FAST_LOG2, 25, auto-scan period is 2^FAST_LOG2 clk cycles when rate_sel=0
SLOW_LOG2, 27, auto-scan period is 2^SLOW_LOG2 clk cycles when rate_sel=1
MARK_EN, {NCH{1'b1}}, per-channel mask; bit c=1 inserts END_MARK after the last index of channel c
END_MARK, 32'hFFFFFFFF, marker word

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
ch_sel  in  NCH  one-hot channel select (board switches)
last_idx  in  NCH*IDX_W  per-channel highest valid index; channel c occupies bits [c*IDX_W +: IDX_W]
rate_sel  in  1  0=fast period, 1=slow period
step_mode  in  1  1=advance only on step_btn rising edge; 0=advance on prescaler tick
step_btn  in  1  step request, level; internally edge-detected
hold  in  1  freeze index; data keeps refreshing
rd_ch  out  $clog2(NCH)  registered probe channel address
rd_idx  out  IDX_W  registered probe index address
rd_data  in  DATA_W  probe word for (rd_ch, rd_idx), combinational from the system
disp_data  out  DATA_W  word to display
disp_ch  out  $clog2(NCH)  channel tag aligned with disp_data
disp_idx  out  IDX_W  index tag aligned with disp_data
disp_mark  out  1  high while disp_data is END_MARK
tick  out  1  one-cycle advance strobe, for debug

Behaviour:
- Reset: all registers and outputs are 0. This includes the prescaler, state=IDLE, rd_ch, rd_idx, disp_*, tick, and the step edge register.
- Prescaler: free-running DIV_W=SLOW_LOG2 bit counter.
- Auto tick: fires when the low k bits of the prescaler are all ones, where k = rate_sel ? SLOW_LOG2 : FAST_LOG2.
  - Exactly one cycle per 2^k cycles.
  - Changing rate_sel never produces a double tick.
- Advance event adv:
  - step_mode=0: adv = auto tick.
  - step_mode=1: adv = step_btn & ~step_btn_q.
  - adv is suppressed while hold=1.
  - The tick output mirrors adv.
- Channel decode: ch_sel is valid when exactly one bit is set; cur = index of that bit. ch_q holds the previously registered ch_sel.
- FSM states: IDLE, SCAN, MARK.
  - IDLE: ch_sel invalid. rd_ch=0, rd_idx=0, so channel 0 index 0 is shown live. Go to SCAN with rd_ch=cur, rd_idx=0 on the first cycle ch_sel becomes valid.
  - SCAN, ch_sel changed (ch_sel != ch_q): rd_ch=cur, rd_idx=0, no advance, even if adv is also set. Change wins over adv.
  - SCAN, ch_sel becomes invalid: go to IDLE.
  - SCAN, adv with rd_idx < last: rd_idx+1.
  - SCAN, adv with rd_idx == last: if MARK_EN[rd_ch], go to MARK; else rd_idx=0 (wrap).
  - MARK, next adv: rd_idx=0, go to SCAN.
  - MARK, channel change or invalid: same handling as SCAN.
- Datapath latency: disp_* registers every cycle from the current rd_* and rd_data, so they are 1 cycle behind rd_*.
  - In MARK: disp_data=END_MARK, disp_mark=1, disp_idx=last.
  - Otherwise: disp_mark=0.
- last_idx=0: each adv goes straight to MARK, or stays at index 0 when MARK is disabled.
- last_idx is sampled live. If it drops below rd_idx, the next adv behaves as the ==last case: MARK or wrap.
- Async reset mid-sweep returns everything to the reset state immediately. The sweep restarts at index 0 after release.

Decomposition:
- Package dbg_scan_pkg: state enum (IDLE/SCAN/MARK), the END_MARK default, and a onehot_to_idx function with a valid flag.
- Sub-module dbg_tick_gen: prescaler, rate select and step edge detect, producing adv. Separating it lets the bench run it with small LOG2 values.
- Top holds the FSM and the display registers.

Test Plan:
- Test parameters: FAST_LOG2=2, SLOW_LOG2=4, NCH=4, IDX_W=3. After reset, ch_sel=0001, last=3, step_mode=0.
  -> rd_idx advances every 4 cycles as 0,1,2,3, then MARK (disp_data=FFFFFFFF, disp_mark=1), then 0. disp_data equals rd_data delayed by 1 cycle.
- Same as above with rate_sel=1 -> advance every 16 cycles. Toggling rate_sel mid-period never yields two ticks within 4 cycles.
- step_mode=1, step_btn held high 10 cycles, then low, then high -> exactly 2 advances. With hold=1, a press -> no advance.
- Set ch_sel 0001 -> 0100 in the same cycle as a tick, with rd_idx=2 -> rd_ch=2, rd_idx=0, no increment.
- ch_sel=0110 -> IDLE, rd_ch=0, rd_idx=0. MARK_EN=4'b1110 on channel 0 with last=1 -> 0,1,0 with no marker.
- Assert rstn=0 while in MARK -> all outputs 0 asynchronously. After release, the sweep resumes at index 0 of the selected channel.

Source files
------------

// File: rtl/dbg_scan_pkg.sv
// Shared types and helpers for the debug-view scanner.
//   scan_state_e  : scanner FSM state encoding
//   END_MARK_DEF  : default end-of-sweep marker word
//   onehot_to_idx : converts a switch vector into a channel index plus a
//                   flag that is set only when exactly one bit is high
package dbg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_MARK = 2'd2
    } scan_state_e;

    localparam logic [31:0] END_MARK_DEF = 32'hFFFF_FFFF;

    // Widest switch vector the decoder accepts; callers zero-extend.
    localparam int MAX_CH   = 32;
    localparam int MAX_CH_W = 5;

    typedef struct packed {
        logic                valid;
        logic [MAX_CH_W-1:0] idx;
    } ch_dec_t;

    function automatic ch_dec_t onehot_to_idx(input logic [MAX_CH-1:0] vec);
        ch_dec_t     dec;
        int unsigned hits;
        dec  = '0;
        hits = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) begin
                hits++;
                dec.idx = MAX_CH_W'(i);
            end
        end
        dec.valid = (hits == 1);
        return dec;
    endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// Advance-event generator for the debug scanner.
//   clk_i, rstn_i   : clock, async active-low reset
//   rate_sel_i      : 0 = period 2^FAST_LOG2, 1 = period 2^SLOW_LOG2
//   step_mode_i     : 1 = advance on step_btn_i rising edge only
//   step_btn_i      : step request level
//   hold_i          : suppress all advances
//   adv_o           : single-cycle advance request (combinational)
module dbg_tick_gen
    import dbg_scan_pkg::*;
#(
    parameter int FAST_LOG2 = 25,
    parameter int SLOW_LOG2 = 27
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rate_sel_i,
    input  logic step_mode_i,
    input  logic step_btn_i,
    input  logic hold_i,
    output logic adv_o
);

    logic [SLOW_LOG2-1:0] presc_q;
    logic                 step_btn_q;
    logic                 fast_hit;
    logic                 slow_hit;
    logic                 auto_tick;
    logic                 step_edge;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q    <= '0;
            step_btn_q <= 1'b0;
        end else begin
            presc_q    <= presc_q + SLOW_LOG2'(1);
            step_btn_q <= step_btn_i;
        end
    end

    // Both rates decode the same free-running counter, so every slow hit is
    // also a fast hit; switching rate can only drop ticks, never add one.
    assign fast_hit  = &presc_q[FAST_LOG2-1:0];
    assign slow_hit  = &presc_q;
    assign auto_tick = rate_sel_i ? slow_hit : fast_hit;
    assign step_edge = step_btn_i & ~step_btn_q;
    assign adv_o     = ~hold_i & (step_mode_i ? step_edge : auto_tick);

endmodule

// File: rtl/dbg_scan_ctrl.sv
// Debug-view scanner: walks an index through the selected probe channel
// and presents the probed word to the seven-segment driver.
//   clk_i, rstn_i             : clock, async active-low reset
//   ch_sel_i    [NCH]         : one-hot channel select switches
//   last_idx_i  [NCH*IDX_W]   : per-channel highest valid index
//   rate_sel_i, step_mode_i,
//   step_btn_i, hold_i        : advance control (see dbg_tick_gen)
//   rd_ch_o, rd_idx_o         : registered probe address
//   rd_data_i   [DATA_W]      : probe word for rd_ch_o/rd_idx_o
//   disp_data_o/ch_o/idx_o    : displayed word and its tags, 1 cycle after rd_*
//   disp_mark_o               : displayed word is the end marker
//   tick_o                    : pulses in the cycle a new index appears
//
// state | meaning
// IDLE  | switches not one-hot; probe channel 0 index 0 shown live
// SCAN  | walking indices 0..last of the selected channel
// MARK  | end-of-sweep marker displayed after the last index
module dbg_scan_ctrl
    import dbg_scan_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                NCH       = 4,
    parameter int                IDX_W     = 6,
    parameter int                FAST_LOG2 = 25,
    parameter int                SLOW_LOG2 = 27,
    parameter logic [NCH-1:0]    MARK_EN   = {NCH{1'b1}},
    parameter logic [DATA_W-1:0] END_MARK  = DATA_W'(END_MARK_DEF)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NCH-1:0]           ch_sel_i,
    input  logic [NCH*IDX_W-1:0]     last_idx_i,
    input  logic                     rate_sel_i,
    input  logic                     step_mode_i,
    input  logic                     step_btn_i,
    input  logic                     hold_i,
    output logic [$clog2(NCH)-1:0]   rd_ch_o,
    output logic [IDX_W-1:0]         rd_idx_o,
    input  logic [DATA_W-1:0]        rd_data_i,
    output logic [DATA_W-1:0]        disp_data_o,
    output logic [$clog2(NCH)-1:0]   disp_ch_o,
    output logic [IDX_W-1:0]         disp_idx_o,
    output logic                     disp_mark_o,
    output logic                     tick_o
);

    localparam int CH_W = $clog2(NCH);

    logic              adv;
    ch_dec_t           dec;
    logic [CH_W-1:0]   cur;
    logic [IDX_W-1:0]  last_cur;

    scan_state_e       state_q;
    logic [NCH-1:0]    ch_q;
    logic [CH_W-1:0]   rd_ch_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [DATA_W-1:0] disp_data_q;
    logic [CH_W-1:0]   disp_ch_q;
    logic [IDX_W-1:0]  disp_idx_q;
    logic              disp_mark_q;
    logic              tick_q;

    dbg_tick_gen #(
        .FAST_LOG2 (FAST_LOG2),
        .SLOW_LOG2 (SLOW_LOG2)
    ) u_tick_gen (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rate_sel_i  (rate_sel_i),
        .step_mode_i (step_mode_i),
        .step_btn_i  (step_btn_i),
        .hold_i      (hold_i),
        .adv_o       (adv)
    );

    assign dec      = onehot_to_idx(MAX_CH'(ch_sel_i));
    assign cur      = CH_W'(dec.idx);
    // last_idx is used live, so a shrinking limit takes effect on the next advance
    assign last_cur = last_idx_i[rd_ch_q*IDX_W +: IDX_W];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            rd_ch_q     <= '0;
            rd_idx_q    <= '0;
            disp_data_q <= '0;
            disp_ch_q   <= '0;
            disp_idx_q  <= '0;
            disp_mark_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q    <= adv;
            ch_q      <= ch_sel_i;
            disp_ch_q <= rd_ch_q;
            if (state_q == ST_MARK) begin
                disp_data_q <= END_MARK;
                disp_idx_q  <= last_cur;
                disp_mark_q <= 1'b1;
            end else begin
                disp_data_q <= rd_data_i;
                disp_idx_q  <= rd_idx_q;
                disp_mark_q <= 1'b0;
            end

            // Channel validity and channel changes take priority over advances.
            if (!dec.valid) begin
                state_q  <= ST_IDLE;
                rd_ch_q  <= '0;
                rd_idx_q <= '0;
            end else if (state_q == ST_IDLE || ch_sel_i != ch_q) begin
                state_q  <= ST_SCAN;
                rd_ch_q  <= cur;
                rd_idx_q <= '0;
            end else if (adv) begin
                if (state_q == ST_MARK) begin
                    state_q  <= ST_SCAN;
                    rd_idx_q <= '0;
                end else if (rd_idx_q < last_cur) begin
                    rd_idx_q <= rd_idx_q + IDX_W'(1);
                end else if (MARK_EN[rd_ch_q]) begin
                    state_q <= ST_MARK;
                end else begin
                    rd_idx_q <= '0;
                end
            end
        end
    end

    assign rd_ch_o     = rd_ch_q;
    assign rd_idx_o    = rd_idx_q;
    assign disp_data_o = disp_data_q;
    assign disp_ch_o   = disp_ch_q;
    assign disp_idx_o  = disp_idx_q;
    assign disp_mark_o = disp_mark_q;
    assign tick_o      = tick_q;

endmodule
